// File: rtl/mac_pkg.sv
// Shared definitions for the fusable MAC cluster: mode encodings, the
// operand/accumulator width rule and the mode-to-group-size mapping.
package mac_pkg;

  typedef enum logic [1:0] {
    MAC_SINGLE = 2'd0,
    MAC_DUAL   = 2'd1,
    MAC_QUAD   = 2'd2
  } macMode_e;

  localparam int unsigned MAC_ACC_RATIO = 2;

  function automatic bit macWidthOk(input int unsigned minW, input int unsigned accW);
    return accW == MAC_ACC_RATIO * minW;
  endfunction

  // Group size doubles per mode step but never exceeds the lane count.
  function automatic int unsigned macGroupSize(input int unsigned mode, input int unsigned lanes);
    int unsigned g;
    g = 1;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < mode && g < lanes) g = g << 1;
    end
    return g;
  endfunction

endpackage

// File: rtl/mac_cluster_pipe_if.sv
// Operand, preload and result channels of the MAC cluster, each with its own
// valid/ready handshake.
interface mac_cluster_pipe_if #(
  parameter int LANES  = 4,
  parameter int MIN_W  = 32,
  parameter int ACC_W  = 64,
  parameter int MODE_W = 2
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*MIN_W-1:0] a;
  logic [LANES*MIN_W-1:0] b;
  logic [MODE_W-1:0]      mode;
  logic                   acc_en;
  logic                   load_valid;
  logic                   load_ready;
  logic [LANES*ACC_W-1:0] load_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*ACC_W-1:0] out;
  logic [LANES-1:0]       ovf;

  modport master (
    output in_valid, a, b, mode, acc_en, load_valid, load_data, out_ready,
    input  in_ready, load_ready, out_valid, out, ovf
  );

  modport slave (
    input  in_valid, a, b, mode, acc_en, load_valid, load_data, out_ready,
    output in_ready, load_ready, out_valid, out, ovf
  );
endinterface

// File: rtl/mac_fuse_group.sv
// One fused group: G lanes concatenated into a single wide unsigned multiply,
// optionally added onto the group's concatenated accumulator with carry-out.
module mac_fuse_group #(
  parameter int G     = 1,
  parameter int MIN_W = 32,
  parameter int ACC_W = 64
) (
  input  logic [G*MIN_W-1:0] a_i,
  input  logic [G*MIN_W-1:0] b_i,
  input  logic [G*ACC_W-1:0] c_i,
  input  logic               accEn_i,
  output logic [G*ACC_W-1:0] sum_o,
  output logic               carry_o
);
  logic [G*ACC_W-1:0] prod;
  logic [G*ACC_W:0]   total;

  assign prod    = {{(G*ACC_W-G*MIN_W){1'b0}}, a_i} * {{(G*ACC_W-G*MIN_W){1'b0}}, b_i};
  assign total   = {1'b0, c_i} + {1'b0, prod};
  assign sum_o   = accEn_i ? total[G*ACC_W-1:0] : prod;
  assign carry_o = accEn_i && total[G*ACC_W];
endmodule

// File: rtl/mac_cluster_pipe.sv
// Two-stage MAC cluster: S1 registers the beat, S2 updates the accumulators
// using whichever lane grouping the beat's mode selects.
module mac_cluster_pipe
  import mac_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int MIN_W  = 32,
  parameter int ACC_W  = 64,
  parameter int MODE_W = 2
) (
  input logic               clk,
  input logic               reset,
  mac_cluster_pipe_if.slave bus
);
  localparam int NSIZES = $clog2(LANES) + 1;

  if (!macWidthOk(MIN_W, ACC_W)) begin : gBadWidth
    $error("mac_cluster_pipe: ACC_W must equal 2*MIN_W");
  end
  if (LANES < 1 || LANES > 16 || (LANES & (LANES - 1)) != 0) begin : gBadLanes
    $error("mac_cluster_pipe: LANES must be a power of two in 1..16");
  end

  logic                   s1Valid_q, s1Valid_d;
  logic [LANES*MIN_W-1:0] s1A_q, s1A_d;
  logic [LANES*MIN_W-1:0] s1B_q, s1B_d;
  logic [MODE_W-1:0]      s1Mode_q, s1Mode_d;
  logic                   s1AccEn_q, s1AccEn_d;
  logic                   outValid_q, outValid_d;
  logic [LANES*ACC_W-1:0] acc_q, acc_d;
  logic [LANES-1:0]       ovf_q, ovf_d;

  logic stall, inFire, loadFire;

  assign stall          = outValid_q && !bus.out_ready;
  assign bus.in_ready   = reset && !stall && !bus.load_valid;
  assign bus.load_ready = reset && !s1Valid_q && !outValid_q;
  assign inFire         = bus.in_valid && bus.in_ready;
  assign loadFire       = bus.load_valid && bus.load_ready;

  assign bus.out_valid = outValid_q;
  assign bus.out       = acc_q;
  assign bus.ovf       = ovf_q;

  // Every candidate grouping is computed in parallel; the S1 mode picks one.
  logic [NSIZES-1:0][LANES*ACC_W-1:0] candAcc;
  logic [NSIZES-1:0][LANES-1:0]       candOvf;

  for (genvar m = 0; m < NSIZES; m++) begin : gSize
    localparam int G = 1 << m;
    for (genvar k = 0; k < LANES / G; k++) begin : gGroup
      logic [G*ACC_W-1:0] sum;
      logic               carry;

      mac_fuse_group #(.G(G), .MIN_W(MIN_W), .ACC_W(ACC_W)) uGroup (
        .a_i     (s1A_q[k*G*MIN_W +: G*MIN_W]),
        .b_i     (s1B_q[k*G*MIN_W +: G*MIN_W]),
        .c_i     (acc_q[k*G*ACC_W +: G*ACC_W]),
        .accEn_i (s1AccEn_q),
        .sum_o   (sum),
        .carry_o (carry)
      );

      assign candAcc[m][k*G*ACC_W +: G*ACC_W] = sum;
      assign candOvf[m][k*G +: G]             = {G{carry}};
    end
  end

  logic [LANES*ACC_W-1:0] fusedAcc;
  logic [LANES-1:0]       fusedOvf;

  always_comb begin
    fusedAcc = candAcc[0];
    fusedOvf = candOvf[0];
    for (int m = 1; m < NSIZES; m++) begin
      if (macGroupSize(32'(s1Mode_q), LANES) == (32'd1 << m)) begin
        fusedAcc = candAcc[m];
        fusedOvf = candOvf[m];
      end
    end
  end

  // A load can only fire with the pipe empty, so it never races a beat.
  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1A_d      = s1A_q;
    s1B_d      = s1B_q;
    s1Mode_d   = s1Mode_q;
    s1AccEn_d  = s1AccEn_q;
    outValid_d = outValid_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    if (loadFire) begin
      acc_d = bus.load_data;
      ovf_d = '0;
    end else if (!stall) begin
      s1Valid_d = inFire;
      if (inFire) begin
        s1A_d     = bus.a;
        s1B_d     = bus.b;
        s1Mode_d  = bus.mode;
        s1AccEn_d = bus.acc_en;
      end
      outValid_d = s1Valid_q;
      if (s1Valid_q) begin
        acc_d = fusedAcc;
        ovf_d = ovf_q | fusedOvf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1Valid_q  <= 1'b0;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s1Mode_q   <= '0;
      s1AccEn_q  <= 1'b0;
      outValid_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1A_q      <= s1A_d;
      s1B_q      <= s1B_d;
      s1Mode_q   <= s1Mode_d;
      s1AccEn_q  <= s1AccEn_d;
      outValid_q <= outValid_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end
endmodule

// File: tb/tb_mac_cluster_pipe.sv
// Bench for mac_cluster_pipe: a table of single-beat vectors with constant
// expectations, a reference-model scoreboard, and hand-written flow sequences.
module tb_mac_cluster_pipe;
  import mac_pkg::*;

  localparam int LANES  = 4;
  localparam int MIN_W  = 32;
  localparam int ACC_W  = 64;
  localparam int MODE_W = 2;
  localparam int AW     = LANES * MIN_W;
  localparam int CW     = LANES * ACC_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_cluster_pipe_if #(.LANES(LANES), .MIN_W(MIN_W), .ACC_W(ACC_W), .MODE_W(MODE_W)) bus ();

  mac_cluster_pipe #(.LANES(LANES), .MIN_W(MIN_W), .ACC_W(ACC_W), .MODE_W(MODE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [CW-1:0]    acc;
    logic [LANES-1:0] ovf;
  } exp_t;

  typedef struct {
    string             name;
    logic [CW-1:0]     loadData;
    logic [AW-1:0]     a;
    logic [AW-1:0]     b;
    logic [MODE_W-1:0] mode;
    logic              accEn;
    logic [CW-1:0]     expOut;
    logic [LANES-1:0]  expOvf;
  } vec_t;

  exp_t             sbQ[$];
  logic [CW-1:0]    gotOut[$];
  logic [LANES-1:0] gotOvf[$];
  int               gotCycle[$];
  logic [CW-1:0]    modelAcc;
  logic [LANES-1:0] modelOvf;
  vec_t             vecs[6];

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;
  bit beatFired, loadFired, outValidSeen;

  localparam logic [ACC_W-1:0] ONES = {ACC_W{1'b1}};

  function automatic logic [ACC_W-1:0] lane(input logic [CW-1:0] v, input int i);
    return v[i*ACC_W +: ACC_W];
  endfunction

  task automatic checkVal(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: wide arithmetic on masked slices of a 512-bit scratch value.
  task automatic modelBeat(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [MODE_W-1:0] mode, input logic accEn);
    int g;
    logic [2*CW-1:0] aFull, bFull, old, nxt, mA, mC, aw, bw, cw, p, s;
    exp_t e;
    g = 1;
    for (int i = 0; i < int'(mode); i++) if (g < LANES) g = g * 2;
    aFull = '0; aFull[AW-1:0] = a;
    bFull = '0; bFull[AW-1:0] = b;
    old = '0; old[CW-1:0] = modelAcc;
    nxt = old;
    mA = {(2*CW){1'b1}} >> (2*CW - g*MIN_W);
    mC = {(2*CW){1'b1}} >> (2*CW - g*ACC_W);
    for (int k = 0; k < LANES / g; k++) begin
      aw = (aFull >> (k*g*MIN_W)) & mA;
      bw = (bFull >> (k*g*MIN_W)) & mA;
      cw = (old >> (k*g*ACC_W)) & mC;
      p  = aw * bw;
      s  = accEn ? cw + p : p;
      if (accEn && s[g*ACC_W]) begin
        for (int j = 0; j < g; j++) modelOvf[k*g+j] = 1'b1;
      end
      s   = s & mC;
      nxt = (nxt & ~(mC << (k*g*ACC_W))) | (s << (k*g*ACC_W));
    end
    modelAcc = nxt[CW-1:0];
    e.acc = modelAcc;
    e.ovf = modelOvf;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    gotOut.push_back(bus.out);
    gotOvf.push_back(bus.ovf);
    gotCycle.push_back(cycleNo);
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected result: got %h, expected none", bus.out);
    end else begin
      e = sbQ.pop_front();
      checkVal("scoreboard out", bus.out, e.acc);
      checkVal("scoreboard ovf", CW'(bus.ovf), CW'(e.ovf));
    end
  endtask

  // Observe handshakes at the negedge, then let the posedge commit them.
  task automatic tick();
    @(negedge clk);
    cycleNo++;
    beatFired    = 1'b0;
    loadFired    = 1'b0;
    outValidSeen = bus.out_valid;
    if (!reset) begin
      sbQ.delete();
      modelAcc = '0;
      modelOvf = '0;
    end else begin
      if (bus.out_valid && bus.out_ready) checkOutput();
      if (bus.load_valid && bus.load_ready) begin
        loadFired = 1'b1;
        modelAcc  = bus.load_data;
        modelOvf  = '0;
      end
      if (bus.in_valid && bus.in_ready) begin
        beatFired = 1'b1;
        modelBeat(bus.a, bus.b, bus.mode, bus.acc_en);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doLoad(input logic [CW-1:0] data);
    bus.load_data  = data;
    bus.load_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (loadFired) break;
    end
    if (!loadFired) checkInt("load handshake timeout", 0, 1);
    bus.load_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] a, input logic [AW-1:0] b,
                               input logic [MODE_W-1:0] mode, input logic accEn);
    bus.a        = a;
    bus.b        = b;
    bus.mode     = mode;
    bus.acc_en   = accEn;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (beatFired) break;
    end
    if (!beatFired) checkInt("beat handshake timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResults(input int n, input int bound);
    for (int i = 0; i < bound && gotOut.size() < n; i++) tick();
    if (gotOut.size() < n) checkInt("result wait timeout", gotOut.size(), n);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base, startCyc, accepted, idx, res0;

    vecs[0] = '{name:"single mul", loadData:'0,
                a:{32'd0, 32'd0, 32'd7, 32'd3}, b:{32'd0, 32'd0, 32'd9, 32'd5},
                mode:MAC_SINGLE, accEn:1'b0,
                expOut:{64'd0, 64'd0, 64'd63, 64'd15}, expOvf:4'b0000};
    vecs[1] = '{name:"dual mul", loadData:'0,
                a:{32'd4, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF},
                b:{32'd5, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF},
                mode:MAC_DUAL, accEn:1'b0,
                expOut:{64'd20, 64'h0000001600000006, 64'hFFFFFFFFFFFFFFFE, 64'd1},
                expOvf:4'b0000};
    vecs[2] = '{name:"quad acc ovf", loadData:{ONES, ONES, ONES, ONES},
                a:{32'd0, 32'd0, 32'd0, 32'd1}, b:{32'd0, 32'd0, 32'd0, 32'd1},
                mode:MAC_QUAD, accEn:1'b1, expOut:'0, expOvf:4'b1111};
    vecs[3] = '{name:"mode clamp", loadData:{64'd0, 64'd0, 64'd0, 64'd5},
                a:{32'd0, 32'd0, 32'd0, 32'd2}, b:{32'd0, 32'd0, 32'd0, 32'd2},
                mode:2'd3, accEn:1'b1,
                expOut:{64'd0, 64'd0, 64'd0, 64'd9}, expOvf:4'b0000};
    vecs[4] = '{name:"single acc carry", loadData:{64'd0, 64'd0, ONES, 64'd1},
                a:{32'd0, 32'd0, 32'd1, 32'd1}, b:{32'd0, 32'd0, 32'd1, 32'd1},
                mode:MAC_SINGLE, accEn:1'b1,
                expOut:{64'd0, 64'd0, 64'd0, 64'd2}, expOvf:4'b0010};
    vecs[5] = '{name:"dual carry ripple", loadData:{64'd0, 64'd0, 64'd0, ONES},
                a:{32'd0, 32'd0, 32'd0, 32'd1}, b:{32'd0, 32'd0, 32'd0, 32'd1},
                mode:MAC_DUAL, accEn:1'b1,
                expOut:{64'd0, 64'd0, 64'd1, 64'd0}, expOvf:4'b0000};

    reset          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.mode       = '0;
    bus.acc_en     = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.out_ready  = 1'b1;
    modelAcc       = '0;
    modelOvf       = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkInt("in_ready in reset", int'(bus.in_ready), 0);
    checkInt("load_ready in reset", int'(bus.load_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkInt("reset out_valid", int'(bus.out_valid), 0);
    checkVal("reset out", bus.out, '0);
    checkVal("reset ovf", CW'(bus.ovf), '0);
    checkInt("in_ready after reset", int'(bus.in_ready), 1);
    checkInt("load_ready after reset", int'(bus.load_ready), 1);

    // Single-beat vectors with hand-computed results.
    foreach (vecs[i]) begin
      doLoad(vecs[i].loadData);
      base = gotOut.size();
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].accEn);
      startCyc = cycleNo;
      waitResults(base + 1, 10);
      if (gotOut.size() > base) begin
        checkVal({vecs[i].name, " out"}, gotOut[base], vecs[i].expOut);
        checkVal({vecs[i].name, " ovf"}, CW'(gotOvf[base]), CW'(vecs[i].expOvf));
        checkInt({vecs[i].name, " latency"}, gotCycle[base] - startCyc, 2);
        tick();
        checkInt({vecs[i].name, " single-cycle valid"}, int'(outValidSeen), 0);
      end
    end

    // Back-to-back accumulation on lane 0.
    doLoad({64'd0, 64'd0, 64'd0, 64'd100});
    base = gotOut.size();
    bus.a = {32'd0, 32'd0, 32'd0, 32'd2};
    bus.b = {32'd0, 32'd0, 32'd0, 32'd7};
    bus.mode = MAC_SINGLE;
    bus.acc_en = 1'b1;
    bus.in_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 10 && accepted < 3; i++) begin
      tick();
      if (beatFired) accepted++;
    end
    bus.in_valid = 1'b0;
    checkInt("acc beats accepted", accepted, 3);
    waitResults(base + 3, 10);
    if (gotOut.size() >= base + 3) begin
      checkVal("acc seq 0", CW'(lane(gotOut[base], 0)), CW'(114));
      checkVal("acc seq 1", CW'(lane(gotOut[base+1], 0)), CW'(128));
      checkVal("acc seq 2", CW'(lane(gotOut[base+2], 0)), CW'(142));
      checkInt("acc seq consecutive", gotCycle[base+2] - gotCycle[base], 2);
    end

    // Back-pressure: two beats fill the pipe, then everything holds.
    base = gotOut.size();
    bus.out_ready = 1'b0;
    idx = 0;
    bus.a = {32'd0, 32'd0, 32'd0, 32'd1};
    bus.b = {32'd0, 32'd0, 32'd0, 32'd10};
    bus.acc_en = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (beatFired) begin
        idx++;
        bus.a = {32'd0, 32'd0, 32'd0, 32'(idx + 1)};
      end
    end
    checkInt("bp accepted while stalled", idx, 2);
    checkInt("bp in_ready low", int'(bus.in_ready), 0);
    checkInt("bp out_valid held", int'(bus.out_valid), 1);
    checkVal("bp out held", CW'(lane(bus.out, 0)), CW'(10));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && idx < 4; i++) begin
      tick();
      if (beatFired) begin
        idx++;
        bus.a = {32'd0, 32'd0, 32'd0, 32'(idx + 1)};
      end
    end
    bus.in_valid = 1'b0;
    waitResults(base + 4, 20);
    repeat (3) tick();
    checkInt("bp result count", gotOut.size() - base, 4);
    if (gotOut.size() >= base + 4) begin
      for (int j = 0; j < 4; j++) begin
        res0 = 10 * (j + 1);
        checkVal($sformatf("bp order %0d", j), CW'(lane(gotOut[base+j], 0)), CW'(res0));
      end
    end

    // A pending load blocks new beats and waits for the pipe to drain.
    base = gotOut.size();
    bus.a = {32'd0, 32'd0, 32'd0, 32'd1};
    bus.b = {32'd0, 32'd0, 32'd0, 32'd1};
    bus.acc_en = 1'b1;
    bus.in_valid = 1'b1;
    accepted = 0;
    repeat (2) begin
      tick();
      if (beatFired) accepted++;
    end
    checkInt("beats before load", accepted, 2);
    bus.load_data = {64'd4, 64'd3, 64'd2, 64'd1};
    bus.load_valid = 1'b1;
    #1;
    checkInt("in_ready drops for load", int'(bus.in_ready), 0);
    checkInt("load_ready while busy", int'(bus.load_ready), 0);
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (beatFired) accepted++;
      if (loadFired) break;
    end
    checkInt("load fired", int'(loadFired), 1);
    checkInt("results drained before load", gotOut.size() - base, 2);
    checkInt("beats during pending load", accepted, 0);
    bus.load_valid = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) tick();

    // Mid-stream reset after an overflow has set the sticky flags.
    doLoad({ONES, ONES, ONES, ONES});
    base = gotOut.size();
    bus.mode = MAC_QUAD;
    bus.acc_en = 1'b1;
    bus.a = {32'd0, 32'd0, 32'd0, 32'd1};
    bus.b = {32'd0, 32'd0, 32'd0, 32'd1};
    bus.in_valid = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    checkInt("in_ready during reset", int'(bus.in_ready), 0);
    tick();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkInt("post-reset out_valid", int'(bus.out_valid), 0);
    checkVal("post-reset acc", bus.out, '0);
    checkVal("post-reset ovf", CW'(bus.ovf), '0);
    repeat (4) tick();
    checkInt("no results after reset", gotOut.size() - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
